rr_crossbar: RTL and testbench
==============================

RR_CROSSBAR -- requirements
Module: rr_crossbar

Interface
REQ-001 SHALL have parameter NUM_NODES, default 4: count of input ports and of output ports; range 2..16.
REQ-002 SHALL have parameter PKT_W, default 576: packet payload width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: entries per input FIFO; a power of two, at least 2.
REQ-004 SHALL have localparam ID_W = $clog2(NUM_NODES), with a minimum of 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port in_valid, input, [NUM_NODES]: core offers a packet on input i.
REQ-008 SHALL have port in_pkt, input, [NUM_NODES][PKT_W]: packet payload per input.
REQ-009 SHALL have port in_dest, input, [NUM_NODES][ID_W]: destination node per input.
REQ-010 SHALL have port in_ready, output, [NUM_NODES]: input FIFO i can accept a packet this cycle.
REQ-011 SHALL have port out_valid, output, [NUM_NODES]: output register o holds a packet.
REQ-012 SHALL have port out_pkt, output, [NUM_NODES][PKT_W]: delivered payload.
REQ-013 SHALL have port out_src, output, [NUM_NODES][ID_W]: index of the input that sourced the delivered packet.
REQ-014 SHALL have port out_ready, input, [NUM_NODES]: receiving node o consumes out_pkt this cycle.
REQ-015 SHALL have port drop_err, output, [NUM_NODES]: one-cycle pulse; input i discarded a packet whose destination was illegal.

Function
REQ-016 SHALL accept a packet on input i at a rising edge where in_valid[i] and in_ready[i] are both high.
REQ-017 SHALL drive in_ready[i] = !full[i]. When a FIFO is full, a pop in the same cycle does not admit a push; the check is conservative.
REQ-018 SHALL discard, without writing, any accepted packet with in_dest[i] >= NUM_NODES, and SHALL pulse drop_err[i] high for exactly the following cycle.
REQ-019 SHALL keep, for each legal accepted packet, its payload and destination in a per-input FIFO of FIFO_DEPTH entries. Order is preserved.
REQ-020 SHALL present each non-empty FIFO head as a request to exactly one output: its stored destination.
REQ-021 SHALL run one round-robin arbiter per output o, each with a pointer rr_ptr[o] of width ID_W.
REQ-022 SHALL search requests starting at input rr_ptr[o] and ascending modulo NUM_NODES; the first requester found is granted.
REQ-023 SHALL grant output o only in a cycle where the load condition holds: out_valid[o] low, or out_ready[o] high.
REQ-024 On a grant to input g at output o, at the next edge the block SHALL:
- load out_pkt[o] with the head payload and out_src[o] with g;
- set out_valid[o];
- pop FIFO g;
- set rr_ptr[o] = (g+1) mod NUM_NODES.
REQ-025 SHALL leave rr_ptr[o] unchanged in any cycle with no grant at output o.
REQ-026 SHALL clear out_valid[o] at the edge where out_ready[o] is high and no grant occurs. Back-to-back delivery at one packet per cycle per output is allowed.
REQ-027 SHALL hold out_pkt[o] and out_src[o] stable while out_valid[o] is high and out_ready[o] is low.
REQ-028 SHALL deliver an accepted packet with a minimum latency of 2 edges: accepted at edge k, head visible in cycle k+1, out_valid high after edge k+1 when uncontended.
REQ-029 SHALL allow every output to grant in the same cycle; distinct outputs never contend for the same input.
REQ-030 SHALL allow a push and a pop on the same non-full FIFO in one cycle, with the occupancy count unchanged.
REQ-031 SHALL guarantee that a continuously requesting input is granted within NUM_NODES grants of its output.

Reset
REQ-032 While rst is high, the block SHALL hold:
- all FIFOs empty;
- out_valid = 0, out_pkt = 0, out_src = 0;
- rr_ptr = 0;
- drop_err = 0;
- in_ready = 0.
REQ-033 On assertion of rst mid-operation, all queued and in-flight packets SHALL be discarded with no partial delivery. in_ready SHALL return to all-ones in the first cycle after rst deasserts.

Verification
REQ-034 Single packet: NUM_NODES=4, input 1 sends dest 3, out_ready all high -> out_valid[3] high exactly 2 edges later, out_src[3] = 1, payload matches, all other outputs remain idle.
REQ-035 Contention and fairness: inputs 0, 1, 2 each stream dest 0 continuously -> out_src[0] follows 0, 1, 2, 0, 1, 2...; no input waits more than 3 grants.
REQ-036 Backpressure: out_ready[2] held low while 5 packets target 2 from input 0, FIFO_DEPTH=4 -> out holds packet 1 stable; the FIFO fills; in_ready[0] falls after 4 further packets; release delivers all in order.
REQ-037 Illegal destination: NUM_NODES=3, in_dest=3 -> no FIFO write, drop_err pulse lasting one cycle, no output activity.
REQ-038 Mid-traffic reset: rst asserted asynchronously between edges with all FIFOs non-empty -> outputs go to zero immediately; after release, nothing stale is delivered and in_ready is all ones.
REQ-039 Parallel permutation: inputs 0..3 send to 3, 2, 1, 0 simultaneously -> all four out_valid high on the same cycle, with correct out_src values.

Source files
------------

// File: rtl/rr_crossbar.sv
// rtl/rr_crossbar.sv - NxN packet crossbar with per-input FIFOs and per-output round-robin arbiters
//
// Ports:
//   clk, rst                               - clock; asynchronous active-high reset
//   in_valid, in_pkt, in_dest, in_ready    - per-input packet offer (payload + destination node)
//   out_valid, out_pkt, out_src, out_ready - per-output delivery register (payload + source node)
//   drop_err                               - per-input one-cycle pulse: packet with illegal destination discarded

module rr_crossbar #(
  parameter  int NUM_NODES  = 4,
  parameter  int PKT_W      = 576,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_W       = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_NODES-1:0]            in_valid,
  input  logic [NUM_NODES-1:0][PKT_W-1:0] in_pkt,
  input  logic [NUM_NODES-1:0][ID_W-1:0]  in_dest,
  output logic [NUM_NODES-1:0]            in_ready,
  output logic [NUM_NODES-1:0]            out_valid,
  output logic [NUM_NODES-1:0][PKT_W-1:0] out_pkt,
  output logic [NUM_NODES-1:0][ID_W-1:0]  out_src,
  input  logic [NUM_NODES-1:0]            out_ready,
  output logic [NUM_NODES-1:0]            drop_err
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  // Per-input FIFO storage. Depth is a power of two so the pointers wrap naturally.
  logic [PKT_W-1:0] pkt_mem  [NUM_NODES][FIFO_DEPTH];
  logic [ID_W-1:0]  dest_mem [NUM_NODES][FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr   [NUM_NODES];
  logic [AW-1:0]    rd_ptr   [NUM_NODES];
  logic [CW-1:0]    count    [NUM_NODES];

  logic [NUM_NODES-1:0] full;
  logic [NUM_NODES-1:0] empty;
  logic [NUM_NODES-1:0] legal;
  logic [NUM_NODES-1:0] push;
  logic [NUM_NODES-1:0] pop;
  logic [PKT_W-1:0]     head_pkt  [NUM_NODES];
  logic [ID_W-1:0]      head_dest [NUM_NODES];

  // Per-output arbitration state and decisions
  logic [ID_W-1:0]      rr_ptr    [NUM_NODES];
  logic [NUM_NODES-1:0] load;
  logic [NUM_NODES-1:0] grant_vld;
  logic [ID_W-1:0]      grant_idx [NUM_NODES];
  logic [ID_W-1:0]      next_ptr  [NUM_NODES];
  logic [PKT_W-1:0]     grant_pkt [NUM_NODES];

  always_comb begin
    full  = '0;
    empty = '0;
    legal = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      full[i]      = (count[i] == CW'(FIFO_DEPTH));
      empty[i]     = (count[i] == '0);
      legal[i]     = (int'(in_dest[i]) < NUM_NODES);
      head_pkt[i]  = pkt_mem[i][rd_ptr[i]];
      head_dest[i] = dest_mem[i][rd_ptr[i]];
    end
  end

  // Ready ignores a same-cycle pop, so a full FIFO never takes a push.
  assign in_ready = rst ? '0 : ~full;
  // Illegal destinations are accepted (handshake completes) but never written.
  assign push     = in_valid & in_ready & legal;

  // Each FIFO head requests only its own destination, so outputs never compete
  // for the same input and every output may grant in the same cycle.
  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    int              sum;
    idx       = '0;
    found     = 1'b0;
    sum       = 0;
    pop       = '0;
    load      = '0;
    grant_vld = '0;
    for (int o = 0; o < NUM_NODES; o++) begin
      load[o]      = !out_valid[o] || out_ready[o];
      found        = 1'b0;
      grant_idx[o] = '0;
      grant_pkt[o] = '0;
      for (int k = 0; k < NUM_NODES; k++) begin
        sum = int'(rr_ptr[o]) + k;
        if (sum >= NUM_NODES) sum = sum - NUM_NODES;
        idx = ID_W'(sum);
        if (!found && !empty[idx] && (int'(head_dest[idx]) == o)) begin
          found        = 1'b1;
          grant_idx[o] = idx;
          grant_pkt[o] = head_pkt[idx];
        end
      end
      grant_vld[o] = found && load[o];
      next_ptr[o]  = (int'(grant_idx[o]) == NUM_NODES - 1) ? '0 : grant_idx[o] + 1'b1;
      for (int i = 0; i < NUM_NODES; i++) begin
        if (grant_vld[o] && (grant_idx[o] == ID_W'(i))) pop[i] = 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy and drop pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      drop_err <= '0;
    end else begin
      for (int i = 0; i < NUM_NODES; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
      drop_err <= in_valid & in_ready & ~legal;
    end
  end

  // Payload storage has no reset; an empty FIFO is never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_NODES; i++) begin
      if (push[i]) begin
        pkt_mem[i][wr_ptr[i]]  <= in_pkt[i];
        dest_mem[i][wr_ptr[i]] <= in_dest[i];
      end
    end
  end

  // Output registers and round-robin pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_pkt   <= '0;
      out_src   <= '0;
      for (int o = 0; o < NUM_NODES; o++) rr_ptr[o] <= '0;
    end else begin
      for (int o = 0; o < NUM_NODES; o++) begin
        if (grant_vld[o]) begin
          out_valid[o] <= 1'b1;
          out_pkt[o]   <= grant_pkt[o];
          out_src[o]   <= grant_idx[o];
          rr_ptr[o]    <= next_ptr[o];
        end else if (out_ready[o]) begin
          out_valid[o] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_crossbar.sv
// tb/tb_rr_crossbar.sv - scoreboard bench for rr_crossbar (4-node and 3-node instances)
`timescale 1ns/1ps
module tb_rr_crossbar;
  localparam int N  = 4;
  localparam int PW = 64;
  localparam int FD = 4;

  typedef struct packed {
    logic [1:0]    src;
    logic [PW-1:0] pkt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]         in_valid, in_ready, out_valid, out_ready, drop_err;
  logic [N-1:0][PW-1:0] in_pkt, out_pkt;
  logic [N-1:0][1:0]    in_dest, out_src;

  logic [2:0]           n3_in_valid, n3_in_ready, n3_out_valid, n3_out_ready, n3_drop_err;
  logic [2:0][PW-1:0]   n3_in_pkt, n3_out_pkt;
  logic [2:0][1:0]      n3_in_dest, n3_out_src;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q [N][$];
  exp_t got_e;
  exp_t want_e;
  bit   sb_en = 1'b0;

  rr_crossbar #(.NUM_NODES(N), .PKT_W(PW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pkt(in_pkt), .in_dest(in_dest), .in_ready(in_ready),
    .out_valid(out_valid), .out_pkt(out_pkt), .out_src(out_src), .out_ready(out_ready),
    .drop_err(drop_err)
  );

  rr_crossbar #(.NUM_NODES(3), .PKT_W(PW), .FIFO_DEPTH(FD)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(n3_in_valid), .in_pkt(n3_in_pkt), .in_dest(n3_in_dest), .in_ready(n3_in_ready),
    .out_valid(n3_out_valid), .out_pkt(n3_out_pkt), .out_src(n3_out_src), .out_ready(n3_out_ready),
    .drop_err(n3_drop_err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every handshake on the 4-node outputs pops its output's queue.
  always @(negedge clk) begin
    if (sb_en && !rst) begin
      for (int o = 0; o < N; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          got_e.src = out_src[o];
          got_e.pkt = out_pkt[o];
          n_cmp++;
          if (exp_q[o].size() == 0) begin
            n_bad++;
            $display("FAIL sb_out%0d_unexpected: got src=%0d pkt=%h, required no delivery", o, got_e.src, got_e.pkt);
          end else begin
            want_e = exp_q[o].pop_front();
            if (got_e !== want_e) begin
              n_bad++;
              $display("FAIL sb_out%0d: got src=%0d pkt=%h, required src=%0d pkt=%h",
                       o, got_e.src, got_e.pkt, want_e.src, want_e.pkt);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pk(input int src, input int seq);
    return {32'(src), 32'(seq)};
  endfunction

  function automatic exp_t mk(input int src, input logic [PW-1:0] pkt);
    exp_t e;
    e.src = 2'(src);
    e.pkt = pkt;
    return e;
  endfunction

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 && exp_q[3].size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++; if (in_ready !== 4'h0)    begin n_bad++; $display("FAIL reset_in_ready: got %b, required 0000", in_ready); end
    n_cmp++; if (out_valid !== 4'h0)   begin n_bad++; $display("FAIL reset_out_valid: got %b, required 0000", out_valid); end
    n_cmp++; if (out_pkt !== '0)       begin n_bad++; $display("FAIL reset_out_pkt: got %h, required 0", out_pkt); end
    n_cmp++; if (out_src !== '0)       begin n_bad++; $display("FAIL reset_out_src: got %h, required 0", out_src); end
    n_cmp++; if (drop_err !== 4'h0)    begin n_bad++; $display("FAIL reset_drop_err: got %b, required 0000", drop_err); end
    n_cmp++; if (n3_in_ready !== 3'b0) begin n_bad++; $display("FAIL reset_n3_in_ready: got %b, required 000", n3_in_ready); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 4'hF)      begin n_bad++; $display("FAIL release_in_ready: got %b, required 1111", in_ready); end
    n_cmp++; if (n3_in_ready !== 3'b111) begin n_bad++; $display("FAIL release_n3_in_ready: got %b, required 111", n3_in_ready); end
  endtask

  task automatic test_single();
    out_ready = '1;
    in_valid[1] = 1'b1;
    in_dest[1]  = 2'd3;
    in_pkt[1]   = pk(1, 'h0A11);
    exp_q[3].push_back(mk(1, pk(1, 'h0A11)));
    tick();
    in_valid = '0;
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL single_edge1: got %b, required 0000", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 4'b1000) begin n_bad++; $display("FAIL single_edge2_valid: got %b, required 1000", out_valid); end
    n_cmp++; if (out_src[3] !== 2'd1)   begin n_bad++; $display("FAIL single_src: got %0d, required 1", out_src[3]); end
    n_cmp++; if (out_pkt[3] !== pk(1, 'h0A11)) begin n_bad++; $display("FAIL single_pkt: got %h, required %h", out_pkt[3], pk(1, 'h0A11)); end
    tick();
    n_cmp++; if (out_valid !== 4'b0000) begin n_bad++; $display("FAIL single_clear: got %b, required 0000", out_valid); end
  endtask

  task automatic test_parallel();
    out_ready = '1;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b1;
      in_dest[i]  = 2'(3 - i);
      in_pkt[i]   = pk(i, 'h500);
      exp_q[3 - i].push_back(mk(i, pk(i, 'h500)));
    end
    tick();
    in_valid = '0;
    tick();
    n_cmp++; if (out_valid !== 4'hF) begin n_bad++; $display("FAIL parallel_valid: got %b, required 1111", out_valid); end
    for (int o = 0; o < N; o++) begin
      n_cmp++;
      if (out_src[o] !== 2'(3 - o)) begin n_bad++; $display("FAIL parallel_src%0d: got %0d, required %0d", o, out_src[o], 3 - o); end
    end
    tick();
  endtask

  task automatic test_contention();
    int   seq [3];
    int   budget;
    bit   ok;
    logic [N-1:0] acc;
    out_ready = '1;
    for (int r = 0; r < 6; r++)
      for (int i = 0; i < 3; i++) exp_q[0].push_back(mk(i, pk(i, r)));
    seq = '{0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      in_dest[i]  = 2'd0;
      in_pkt[i]   = pk(i, 0);
      in_valid[i] = 1'b1;
    end
    budget = 0;
    while ((seq[0] < 6 || seq[1] < 6 || seq[2] < 6) && budget < 200) begin
      acc = in_valid & in_ready;
      tick();
      budget++;
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) begin
          seq[i]++;
          in_pkt[i] = pk(i, seq[i]);
          if (seq[i] == 6) in_valid[i] = 1'b0;
        end
      end
    end
    in_valid = '0;
    wait_drain(100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL contention_drain: got %0d left, required 0", exp_q[0].size()); end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    int budget;
    bit ok;
    bit acc;
    out_ready = 4'b1011;
    for (int k = 0; k < 5; k++) exp_q[2].push_back(mk(0, pk(0, 100 + k)));
    n = 0;
    budget = 0;
    in_dest[0]  = 2'd2;
    in_pkt[0]   = pk(0, 100);
    in_valid[0] = 1'b1;
    while (n < 5 && budget < 50) begin
      acc = in_ready[0];
      tick();
      budget++;
      if (acc) begin
        n++;
        in_pkt[0] = pk(0, 100 + n);
      end
    end
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL bp_accepted: got %0d, required 5", n); end
    n_cmp++; if (in_ready[0] !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %b, required 0", in_ready[0]); end
    // Keep offering an extra packet while full; it must never be taken.
    in_pkt[0] = pk(0, 999);
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (out_valid[2] !== 1'b1 || out_pkt[2] !== pk(0, 100) || out_src[2] !== 2'd0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v=%b pkt=%h src=%0d, required v=1 pkt=%h src=0", c, out_valid[2], out_pkt[2], out_src[2], pk(0, 100));
      end
      tick();
    end
    in_valid[0] = 1'b0;
    out_ready = '1;
    wait_drain(50, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_drain: got %0d left, required 0", exp_q[2].size()); end
    tick();
    tick();
    n_cmp++; if (in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back: got %b, required 1", in_ready[0]); end
  endtask

  task automatic test_illegal();
    bit quiet;
    n3_out_ready = '1;
    n3_in_valid[1] = 1'b1;
    n3_in_dest[1]  = 2'd3;
    n3_in_pkt[1]   = pk(1, 'hBAD);
    n_cmp++; if (n3_drop_err !== 3'b000) begin n_bad++; $display("FAIL illegal_pre: got %b, required 000", n3_drop_err); end
    tick();
    n3_in_valid = '0;
    n_cmp++; if (n3_drop_err !== 3'b010) begin n_bad++; $display("FAIL illegal_pulse: got %b, required 010", n3_drop_err); end
    tick();
    n_cmp++; if (n3_drop_err !== 3'b000) begin n_bad++; $display("FAIL illegal_pulse_end: got %b, required 000", n3_drop_err); end
    quiet = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (n3_out_valid !== 3'b000) quiet = 1'b0;
      tick();
    end
    n_cmp++; if (!quiet) begin n_bad++; $display("FAIL illegal_no_output: got activity, required none"); end
    // A legal packet from the same input must not be stuck behind a stored illegal one.
    n3_in_valid[1] = 1'b1;
    n3_in_dest[1]  = 2'd2;
    n3_in_pkt[1]   = pk(1, 'h600);
    tick();
    n3_in_valid = '0;
    tick();
    n_cmp++; if (n3_out_valid !== 3'b100) begin n_bad++; $display("FAIL illegal_follow_valid: got %b, required 100", n3_out_valid); end
    n_cmp++; if (n3_out_src[2] !== 2'd1)  begin n_bad++; $display("FAIL illegal_follow_src: got %0d, required 1", n3_out_src[2]); end
    n_cmp++; if (n3_out_pkt[2] !== pk(1, 'h600)) begin n_bad++; $display("FAIL illegal_follow_pkt: got %h, required %h", n3_out_pkt[2], pk(1, 'h600)); end
    tick();
  endtask

  task automatic test_mid_reset();
    bit quiet;
    out_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b1;
      in_dest[i]  = 2'((i + 1) % 4);
      in_pkt[i]   = pk(i, 'h700);
    end
    tick();
    for (int i = 0; i < N; i++) in_pkt[i] = pk(i, 'h701);
    tick();
    in_valid = '0;
    n_cmp++; if (out_valid !== 4'hF) begin n_bad++; $display("FAIL midrst_pre: got %b, required 1111", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 4'h0) begin n_bad++; $display("FAIL midrst_valid: got %b, required 0000", out_valid); end
    n_cmp++; if (out_pkt !== '0)     begin n_bad++; $display("FAIL midrst_pkt: got %h, required 0", out_pkt); end
    n_cmp++; if (in_ready !== 4'h0)  begin n_bad++; $display("FAIL midrst_ready: got %b, required 0000", in_ready); end
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 4'hF) begin n_bad++; $display("FAIL midrst_release_ready: got %b, required 1111", in_ready); end
    out_ready = '1;
    quiet = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid !== 4'h0) quiet = 1'b0;
    end
    n_cmp++; if (!quiet) begin n_bad++; $display("FAIL midrst_stale: got stale delivery, required none"); end
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = '0;
    in_pkt       = '0;
    in_dest      = '0;
    out_ready    = '0;
    n3_in_valid  = '0;
    n3_in_pkt    = '0;
    n3_in_dest   = '0;
    n3_out_ready = '0;
    test_reset();
    sb_en = 1'b1;
    test_single();
    test_parallel();
    test_contention();
    test_backpressure();
    test_illegal();
    test_mid_reset();
    for (int o = 0; o < N; o++) begin
      n_cmp++;
      if (exp_q[o].size() != 0) begin n_bad++; $display("FAIL sb_leftover%0d: got %0d pending, required 0", o, exp_q[o].size()); end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
